// File: rtl/pkt_ingress_fifo.sv
// Packet ingress FIFO: valid/ready in and out, occupancy and accepted-packet counters.
// Optional per-entry even-parity checking is enabled by defining PKT_FIFO_PARITY_EN.
module pkt_ingress_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_par,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic                     out_par_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              pkt_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [15:0]       pkt_total_reg;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              push;
    logic              pop;

    // Flow control looks only at the registered occupancy, never at out_ready.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign count     = count_reg;
    assign pkt_total = pkt_total_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pkt_total_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                pkt_total_reg <= pkt_total_reg + 16'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= in_data;
        end
    end

    assign out_data = data_mem[rd_ptr_reg];

`ifdef PKT_FIFO_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            par_mem[wr_ptr_reg] <= in_par;
        end
    end

    assign out_par_err = out_valid && ((^out_data) != par_mem[rd_ptr_reg]);
`else
    logic unused_in_par;

    assign unused_in_par = in_par;
    assign out_par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_ingress_fifo.sv
// Randomised self-checking bench for pkt_ingress_fifo against a queue-based reference model.
// Parity expectations follow PKT_FIFO_PARITY_EN the same way the design build does.
module tb_pkt_ingress_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_par = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        out_par_err;
    logic [3:0]  count;
    logic [15:0] pkt_total;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of {parity, data}, plus a 16-bit accepted-packet count.
    logic [8:0]  model_q[$];
    logic [15:0] model_total = '0;

    pkt_ingress_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_par      (in_par),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_par_err (out_par_err),
        .count       (count),
        .pkt_total   (pkt_total)
    );

    always #5 clk = ~clk;

    function automatic logic exp_err();
        logic [8:0] e;
        if (model_q.size() == 0) return 1'b0;
        e = model_q[0];
`ifdef PKT_FIFO_PARITY_EN
        return (^e[7:0]) != e[8];
`else
        return (e[8] & 1'b0);
`endif
    endfunction

    // Called at posedge+1; applies inputs for one cycle and advances the model.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic p, input logic r);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_data   = d;
        in_par    = p;
        out_ready = r;
        @(posedge clk);
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
            model_q.push_back({p, d});
            model_total = model_total + 16'd1;
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic drain();
        while (model_q.size() > 0) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++;
        if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_checks++;
        if (pkt_total !== 16'd0) $display("FAIL reset_pkt_total got %0d want 0", pkt_total); else n_pass++;
        n_checks++;
        if (out_par_err !== 1'b0) $display("FAIL reset_par_err got %b want 0", out_par_err); else n_pass++;
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_single_push();
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b want 1", out_valid); else n_pass++;
        n_checks++;
        if (out_data !== 8'hA5) $display("FAIL single_out_data got %h want a5", out_data); else n_pass++;
        n_checks++;
        if (count !== 4'd1) $display("FAIL single_count got %0d want 1", count); else n_pass++;
        n_checks++;
        if (pkt_total !== 16'd1) $display("FAIL single_pkt_total got %0d want 1", pkt_total); else n_pass++;
        n_checks++;
        drain();
        $display("test_single_push done");
    endtask

    task automatic test_fill_drain();
        logic [15:0] base;
        logic [7:0]  v;
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i);
            drive_cycle(1'b1, v, ^v, 1'b0);
        end
        base = model_total;
        if (count !== 4'd8) $display("FAIL full_count got %0d want 8", count); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++;
        drive_cycle(1'b1, 8'h09, 1'b0, 1'b0);
        if (count !== 4'd8) $display("FAIL ninth_count got %0d want 8", count); else n_pass++;
        n_checks++;
        if (pkt_total !== base) $display("FAIL ninth_pkt_total got %0d want %0d", pkt_total, base); else n_pass++;
        n_checks++;
        for (int i = 1; i <= 8; i++) begin
            if (out_data !== 8'(i)) $display("FAIL drain_data got %h want %h", out_data, 8'(i)); else n_pass++;
            n_checks++;
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        if (out_valid !== 1'b0) $display("FAIL drain_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++;
        $display("test_fill_drain done");
    endtask

    task automatic test_concurrent();
        logic [15:0] base;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        base = model_total;
        if (out_data !== 8'h40) $display("FAIL conc_head got %h want 40", out_data); else n_pass++;
        n_checks++;
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b1);
        if (count !== 4'd4) $display("FAIL conc_count got %0d want 4", count); else n_pass++;
        n_checks++;
        if (pkt_total !== base + 16'd1) $display("FAIL conc_pkt_total got %0d want %0d", pkt_total, base + 16'd1); else n_pass++;
        n_checks++;
        if (out_data !== 8'h41) $display("FAIL conc_next_head got %h want 41", out_data); else n_pass++;
        n_checks++;
        drain();
        $display("test_concurrent done");
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        v = 8'($urandom);
        drive_cycle(1'b1, v, ^v, 1'b0);
        for (int i = 0; i < 19; i++) begin
            v = 8'($urandom);
            if (out_data !== model_q[0][7:0]) $display("FAIL wrap_data got %h want %h", out_data, model_q[0][7:0]); else n_pass++;
            n_checks++;
            drive_cycle(1'b1, v, ^v, 1'b1);
        end
        if (out_data !== model_q[0][7:0]) $display("FAIL wrap_last got %h want %h", out_data, model_q[0][7:0]); else n_pass++;
        n_checks++;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        if (count !== 4'd0) $display("FAIL wrap_count got %0d want 0", count); else n_pass++;
        n_checks++;
        $display("test_wrap done");
    endtask

    task automatic test_parity();
        drive_cycle(1'b1, 8'h03, 1'b1, 1'b0);
        if (out_par_err !== exp_err()) $display("FAIL par_bad got %b want %b", out_par_err, exp_err()); else n_pass++;
        n_checks++;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h03, 1'b0, 1'b0);
        if (out_par_err !== exp_err()) $display("FAIL par_good got %b want %b", out_par_err, exp_err()); else n_pass++;
        n_checks++;
        drain();
        if (out_par_err !== 1'b0) $display("FAIL par_empty got %b want 0", out_par_err); else n_pass++;
        n_checks++;
        $display("test_parity done");
    endtask

    task automatic test_random();
        logic       v;
        logic       r;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            if (count !== 4'(model_q.size())) $display("FAIL rand_count got %0d want %0d", count, model_q.size()); else n_pass++;
            n_checks++;
            if (in_ready !== (model_q.size() != DEPTH)) $display("FAIL rand_in_ready got %b want %b", in_ready, model_q.size() != DEPTH); else n_pass++;
            n_checks++;
            if (out_valid !== (model_q.size() != 0)) $display("FAIL rand_out_valid got %b want %b", out_valid, model_q.size() != 0); else n_pass++;
            n_checks++;
            if (pkt_total !== model_total) $display("FAIL rand_pkt_total got %0d want %0d", pkt_total, model_total); else n_pass++;
            n_checks++;
            if (out_par_err !== exp_err()) $display("FAIL rand_par_err got %b want %b", out_par_err, exp_err()); else n_pass++;
            n_checks++;
            if (model_q.size() != 0) begin
                if (out_data !== model_q[0][7:0]) $display("FAIL rand_data got %h want %h", out_data, model_q[0][7:0]); else n_pass++;
                n_checks++;
            end
            // Alternate fill-biased and drain-biased phases so both full and empty are reached.
            v = ((i / 50) % 2 == 0) ? ($urandom_range(9, 0) < 8) : ($urandom_range(9, 0) < 3);
            r = ((i / 50) % 2 == 0) ? ($urandom_range(9, 0) < 3) : ($urandom_range(9, 0) < 8);
            d = 8'($urandom);
            drive_cycle(v, d, 1'($urandom), r);
        end
        drain();
        $display("test_random done");
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        if (count !== 4'd5) $display("FAIL mid_pre_count got %0d want 5", count); else n_pass++;
        n_checks++;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        model_total = '0;
        if (count !== 4'd0) $display("FAIL mid_count got %0d want 0", count); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++;
        if (pkt_total !== 16'd0) $display("FAIL mid_pkt_total got %0d want 0", pkt_total); else n_pass++;
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (out_valid !== 1'b0) $display("FAIL mid_stale_valid got %b want 0", out_valid); else n_pass++;
            n_checks++;
        end
        drive_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        if (out_data !== 8'h5A) $display("FAIL mid_new_data got %h want 5a", out_data); else n_pass++;
        n_checks++;
        if (count !== 4'd1) $display("FAIL mid_new_count got %0d want 1", count); else n_pass++;
        n_checks++;
        drain();
        $display("test_midreset done");
    endtask

    task automatic test_total_wrap();
        while (model_total != 16'hFFFF) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        if (pkt_total !== 16'hFFFF) $display("FAIL total_max got %h want ffff", pkt_total); else n_pass++;
        n_checks++;
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b1);
        if (pkt_total !== 16'h0000) $display("FAIL total_wrap got %h want 0000", pkt_total); else n_pass++;
        n_checks++;
        drain();
        $display("test_total_wrap done");
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_concurrent();
        test_wrap();
        test_parity();
        test_random();
        test_midreset();
        test_total_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_ingress_fifo.md
PKT_INGRESS_FIFO -- requirements
Module: pkt_ingress_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, packet payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream (driver side) offers a packet.
REQ-006 SHALL have port in_data  input  DATA_W  packet payload.
REQ-007 SHALL have port in_par  input  1  even-parity bit of in_data, supplied by upstream.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a packet this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry available to downstream.
REQ-010 SHALL have port out_data  output  DATA_W  head entry payload.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the head entry.
REQ-012 SHALL have port out_par_err  output  1  head entry parity mismatch.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port pkt_total  output  16  accepted-packet counter.

Function
REQ-015 SHALL accept (push) when in_valid && in_ready are both high at a rising edge.
REQ-016 SHALL deliver (pop) when out_valid && out_ready are both high at a rising edge.
REQ-017 SHALL drive in_ready = (count != DEPTH), combinationally from registered count only; it SHALL NOT depend on out_ready.
REQ-018 SHALL drive out_valid = (count != 0); out_data SHALL be the oldest unpopped entry, read combinationally from storage.
REQ-019 SHALL make a pushed packet visible at out_valid/out_data the cycle after the push edge (1-cycle latency into an empty FIFO).
REQ-020 SHALL preserve strict FIFO order, with read and write pointers wrapping from DEPTH-1 to 0.
REQ-021 SHALL update count by +1 on push-only, -1 on pop-only, and unchanged on simultaneous push and pop.
REQ-022 SHALL ignore in_valid when full, holding data, pointers and count, with no drop and no overwrite.
REQ-023 SHALL ignore out_ready when empty, leaving the pointers unchanged.
REQ-024 SHALL keep out_data stable while out_valid is high and no pop occurs.
REQ-025 SHALL increment pkt_total on each push and wrap from 16'hFFFF to 0.

Reset
REQ-026 SHALL, on rst_n low, immediately clear pointers, count and pkt_total to 0; in_ready SHALL be 1, and out_valid and out_par_err SHALL be 0.
REQ-027 SHALL discard in-flight contents on reset mid-operation; storage contents need not be cleared.
REQ-028 SHALL permit the first push on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL control parity checking with macro PKT_FIFO_PARITY_EN.
REQ-030 With PKT_FIFO_PARITY_EN defined, SHALL store in_par alongside each entry and drive out_par_err = out_valid && (^out_data != stored parity).
REQ-031 Without PKT_FIFO_PARITY_EN, SHALL ignore in_par, store no parity bit, and tie out_par_err to 0; the port list SHALL be identical in both builds.

Verification
REQ-032 SHALL cover: reset, then push 8'hA5 with out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, count=1, pkt_total=1.
REQ-033 SHALL cover: 8 pushes (1..8) with out_ready=0 -> count=8, in_ready=0; a 9th push of 8'h09 is ignored; draining yields 1..8 in order, then out_valid=0.
REQ-034 SHALL cover: FIFO at count=4 with push and pop in the same cycle -> count stays 4, popped entry is the oldest, pkt_total +1.
REQ-035 SHALL cover: 20 push/pop pairs through a DEPTH=8 FIFO -> pointers wrap, output sequence equals input sequence, count returns to 0.
REQ-036 SHALL cover: PKT_FIFO_PARITY_EN defined, push 8'h03 with in_par=1 -> out_par_err=1 while at the head; push 8'h03 with in_par=0 -> out_par_err=0; macro undefined -> out_par_err=0 always.
REQ-037 SHALL cover: rst_n asserted at count=5 mid-stream -> count=0, out_valid=0, in_ready=1, pkt_total=0 in the same cycle; no stale entry appears afterwards.
